// File: rtl/interrupt_ctrl_if.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl_if
// Bundles the signals between the interrupt controller, the peripheral flag
// owners, reg_ctrl (IE/IP) and the core sequencer.
//   interrupt_req_i        7  raw peripheral flags
//   interrupt_ie_i         8  IE register (bit7 = EA)
//   interrupt_ip_i         7  IP register (1 = high priority)
//   interrupt_block_i      1  core busy, blocks new presentations
//   interrupt_ack_i        1  core accepted the presented vector
//   interrupt_reti_i       1  RETI executed
//   interrupt_rdy_o        1  vector valid
//   interrupt_vect_o       3  winning source index or NONE_VECT
//   interrupt_clear_o      7  one-cycle hardware-clear strobes
//   interrupt_in_service_o 2  bit1 high level active, bit0 low level active
//   interrupt_na_o         1  no interrupt in service
// slave modport is the controller, master modport is the surrounding system.
// ---------------------------------------------------------------------------
interface interrupt_ctrl_if;
   logic [6:0] interrupt_req_i;
   logic [7:0] interrupt_ie_i;
   logic [6:0] interrupt_ip_i;
   logic       interrupt_block_i;
   logic       interrupt_ack_i;
   logic       interrupt_reti_i;
   logic       interrupt_rdy_o;
   logic [2:0] interrupt_vect_o;
   logic [6:0] interrupt_clear_o;
   logic [1:0] interrupt_in_service_o;
   logic       interrupt_na_o;

   modport master (
      output interrupt_req_i, interrupt_ie_i, interrupt_ip_i,
             interrupt_block_i, interrupt_ack_i, interrupt_reti_i,
      input  interrupt_rdy_o, interrupt_vect_o, interrupt_clear_o,
             interrupt_in_service_o, interrupt_na_o
   );

   modport slave (
      input  interrupt_req_i, interrupt_ie_i, interrupt_ip_i,
             interrupt_block_i, interrupt_ack_i, interrupt_reti_i,
      output interrupt_rdy_o, interrupt_vect_o, interrupt_clear_o,
             interrupt_in_service_o, interrupt_na_o
   );
endinterface

// File: rtl/interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl
// Two-level priority interrupt arbiter for the 8051-class core. Masks the
// peripheral flags with IE/IP, picks one winner, presents its vector through
// a rdy/ack handshake, tracks nesting with per-level in-service bits and
// pulses hardware-clear strobes back to the flag owners.
//   interrupt_clk_i    block clock (core_clk domain)
//   interrupt_reset_i  asynchronous reset, active-low
//   bus                interrupt_ctrl_if.slave, all handshake/flag signals
// ---------------------------------------------------------------------------
module interrupt_ctrl #(
   parameter int              NUM_SRC       = 7,
   parameter logic [NUM_SRC-1:0] HW_CLEAR_MASK = 7'b0001111,
   parameter logic [2:0]      NONE_VECT     = 3'b111
) (
   input  logic              interrupt_clk_i,
   input  logic              interrupt_reset_i,
   interrupt_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

   state_t               state_q, state_d;
   logic                 rdy_q, rdy_d;
   logic [2:0]           vect_q, vect_d;
   logic                 lvl_q, lvl_d;
   logic [NUM_SRC-1:0]   clear_q, clear_d;
   logic [1:0]           in_service_q, in_service_d;
   logic                 na_q, na_d;

   logic [NUM_SRC-1:0]   pending;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   hi_cand;
   logic [NUM_SRC-1:0]   lo_cand;
   logic                 win_found;
   logic [2:0]           win_idx;
   logic                 win_hi;
   logic [7:0]           frozen_onehot;
   logic [1:0]           after_reti;

   // Masking and nesting-aware eligibility. An active high level shuts
   // everything out; an active low level lets only high-priority sources in.
   always_comb begin
      pending  = bus.interrupt_req_i & bus.interrupt_ie_i[NUM_SRC-1:0]
                 & {NUM_SRC{bus.interrupt_ie_i[7]}};
      eligible = pending;
      if (in_service_q[1]) begin
         eligible = '0;
      end else if (in_service_q[0]) begin
         eligible = pending & bus.interrupt_ip_i;
      end
      hi_cand = eligible & bus.interrupt_ip_i;
      lo_cand = eligible & ~bus.interrupt_ip_i;
   end

   // Winner search: scanning downwards makes the lowest index the last
   // assignment; the high-priority pass runs second so it overrides.
   always_comb begin
      win_found = 1'b0;
      win_idx   = NONE_VECT;
      win_hi    = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (lo_cand[i]) begin
            win_found = 1'b1;
            win_idx   = 3'(i);
            win_hi    = 1'b0;
         end
      end
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (hi_cand[i]) begin
            win_found = 1'b1;
            win_idx   = 3'(i);
            win_hi    = 1'b1;
         end
      end
   end

   // Handshake FSM and in-service bookkeeping. RETI is folded in first so a
   // same-cycle ack sets its level on top of the already-cleared state.
   always_comb begin
      state_d       = state_q;
      rdy_d         = rdy_q;
      vect_d        = vect_q;
      lvl_d         = lvl_q;
      clear_d       = '0;
      frozen_onehot = 8'b1 << vect_q;

      after_reti = in_service_q;
      if (bus.interrupt_reti_i) begin
         after_reti = in_service_q[1] ? {1'b0, in_service_q[0]} : 2'b00;
      end
      in_service_d = after_reti;

      case (state_q)
         IDLE: begin
            if (win_found && !bus.interrupt_block_i) begin
               state_d = PRESENT;
               rdy_d   = 1'b1;
               vect_d  = win_idx;
               lvl_d   = win_hi;
            end
         end
         PRESENT: begin
            if (bus.interrupt_ack_i) begin
               in_service_d = after_reti | (lvl_q ? 2'b10 : 2'b01);
               clear_d      = frozen_onehot[NUM_SRC-1:0] & HW_CLEAR_MASK;
               rdy_d        = 1'b0;
               vect_d       = NONE_VECT;
               state_d      = HOLD;
            end else if (~|(frozen_onehot[NUM_SRC-1:0] & eligible)) begin
               rdy_d   = 1'b0;
               vect_d  = NONE_VECT;
               state_d = IDLE;
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            rdy_d   = 1'b0;
            vect_d  = NONE_VECT;
         end
      endcase

      na_d = ~|in_service_d;
   end

   // State and output registers; reset abandons any handshake in flight.
   always_ff @(posedge interrupt_clk_i or negedge interrupt_reset_i) begin
      if (!interrupt_reset_i) begin
         state_q      <= IDLE;
         rdy_q        <= 1'b0;
         vect_q       <= NONE_VECT;
         lvl_q        <= 1'b0;
         clear_q      <= '0;
         in_service_q <= 2'b00;
         na_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         rdy_q        <= rdy_d;
         vect_q       <= vect_d;
         lvl_q        <= lvl_d;
         clear_q      <= clear_d;
         in_service_q <= in_service_d;
         na_q         <= na_d;
      end
   end

   assign bus.interrupt_rdy_o        = rdy_q;
   assign bus.interrupt_vect_o       = vect_q;
   assign bus.interrupt_clear_o      = clear_q;
   assign bus.interrupt_in_service_o = in_service_q;
   assign bus.interrupt_na_o         = na_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_interrupt_ctrl
// Directed testbench for interrupt_ctrl. Observed outputs are packed as
// {rdy, vect[2:0], clear[6:0], in_service[1:0], na} and compared against
// hand-computed vectors. Inputs change and outputs are sampled on the
// falling edge; the design acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_interrupt_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   interrupt_ctrl_if bus ();

   interrupt_ctrl dut (
      .interrupt_clk_i   (clk),
      .interrupt_reset_i (rst_n),
      .bus               (bus.slave)
   );

   logic [13:0] obs;
   assign obs = {bus.interrupt_rdy_o, bus.interrupt_vect_o, bus.interrupt_clear_o,
                 bus.interrupt_in_service_o, bus.interrupt_na_o};

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One full cycle: through the active edge to the next sampling point.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [6:0] req, input logic [7:0] ie, input logic [6:0] ip,
                        input logic blk, input logic ack, input logic reti);
      bus.interrupt_req_i   = req;
      bus.interrupt_ie_i    = ie;
      bus.interrupt_ip_i    = ip;
      bus.interrupt_block_i = blk;
      bus.interrupt_ack_i   = ack;
      bus.interrupt_reti_i  = reti;
   endtask

   task automatic test_reset();
      logic [13:0] want;
      drive(7'h0, 8'h0, 7'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reset_values got %b want %b", obs, want); end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reset_idle got %b want %b", obs, want); end
   endtask

   task automatic test_single();
      logic [13:0] want;
      drive(7'b0000010, 8'h82, 7'h0, 1'b0, 1'b0, 1'b0);
      tick();
      want = {1'b1, 3'd1, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL single_present got %b want %b", obs, want); end
      bus.interrupt_ack_i = 1'b1;
      tick();
      want = {1'b0, 3'd7, 7'b0000010, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL single_ack got %b want %b", obs, want); end
      bus.interrupt_ack_i = 1'b0;
      bus.interrupt_req_i = 7'b0;
      tick();
      want = {1'b0, 3'd7, 7'b0, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL single_clear_once got %b want %b", obs, want); end
      bus.interrupt_reti_i = 1'b1;
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL single_reti got %b want %b", obs, want); end
   endtask

   task automatic test_priority();
      logic [13:0] want;
      drive(7'b0010101, 8'hFF, 7'b0010000, 1'b0, 1'b0, 1'b0);
      tick();
      want = {1'b1, 3'd4, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL prio_winner got %b want %b", obs, want); end
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b10, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL prio_ack got %b want %b", obs, want); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== want) begin errors++; $display("[TB] FAIL prio_high_blocks cycle %0d got %b want %b", i, obs, want); end
      end
      bus.interrupt_reti_i = 1'b1;
      bus.interrupt_req_i  = 7'b0;
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL prio_reti got %b want %b", obs, want); end
   endtask

   task automatic test_nesting();
      logic [13:0] want;
      drive(7'b0000001, 8'hFF, 7'b0001000, 1'b0, 1'b0, 1'b0);
      tick();
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0000001, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_low_ack got %b want %b", obs, want); end
      tick();
      bus.interrupt_req_i = 7'b0001001;
      tick();
      want = {1'b1, 3'd3, 7'b0, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_high_present got %b want %b", obs, want); end
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      bus.interrupt_req_i = 7'b0000001;
      want = {1'b0, 3'd7, 7'b0001000, 2'b11, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_high_ack got %b want %b", obs, want); end
      tick();
      bus.interrupt_reti_i = 1'b1;
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_reti1 got %b want %b", obs, want); end
      tick();
      bus.interrupt_reti_i = 1'b1;
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_reti2 got %b want %b", obs, want); end
      tick();
      want = {1'b1, 3'd0, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_represent got %b want %b", obs, want); end
      bus.interrupt_req_i = 7'b0;
      tick();
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL nest_flag_drop got %b want %b", obs, want); end
   endtask

   task automatic test_block_withdraw();
      logic [13:0] want;
      drive(7'b0000001, 8'hFF, 7'h0, 1'b1, 1'b0, 1'b0);
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== want) begin errors++; $display("[TB] FAIL block_held cycle %0d got %b want %b", i, obs, want); end
      end
      bus.interrupt_block_i = 1'b0;
      tick();
      want = {1'b1, 3'd0, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL block_release got %b want %b", obs, want); end
      bus.interrupt_ie_i = 8'hFE;
      tick();
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL withdraw_ie got %b want %b", obs, want); end
      drive(7'h0, 8'hFF, 7'h0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reti_ack();
      logic [13:0] want;
      drive(7'b0000001, 8'hFF, 7'b0000010, 1'b0, 1'b0, 1'b0);
      tick();
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      tick();
      bus.interrupt_req_i = 7'b0000011;
      tick();
      want = {1'b1, 3'd1, 7'b0, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reti_ack_present got %b want %b", obs, want); end
      bus.interrupt_ack_i  = 1'b1;
      bus.interrupt_reti_i = 1'b1;
      tick();
      drive(7'h0, 8'hFF, 7'b0000010, 1'b0, 1'b0, 1'b0);
      want = {1'b0, 3'd7, 7'b0000010, 2'b10, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reti_ack_same got %b want %b", obs, want); end
      tick();
      bus.interrupt_reti_i = 1'b1;
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reti_ack_unwind got %b want %b", obs, want); end
   endtask

   task automatic test_idle_events();
      logic [13:0] want;
      drive(7'h0, 8'hFF, 7'h0, 1'b0, 1'b0, 1'b1);
      tick();
      bus.interrupt_reti_i = 1'b0;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL reti_idle got %b want %b", obs, want); end
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL ack_idle got %b want %b", obs, want); end
   endtask

   task automatic test_async_reset();
      logic [13:0] want;
      drive(7'b0000001, 8'hFF, 7'b0000010, 1'b0, 1'b0, 1'b0);
      tick();
      bus.interrupt_ack_i = 1'b1;
      tick();
      bus.interrupt_ack_i = 1'b0;
      bus.interrupt_req_i = 7'b0000011;
      tick();
      tick();
      want = {1'b1, 3'd1, 7'b0, 2'b01, 1'b0};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL areset_setup got %b want %b", obs, want); end
      #2;
      rst_n = 1'b0;
      #1;
      want = {1'b0, 3'd7, 7'b0, 2'b00, 1'b1};
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL areset_immediate got %b want %b", obs, want); end
      tick();
      checks++;
      if (obs !== want) begin errors++; $display("[TB] FAIL areset_held got %b want %b", obs, want); end
      drive(7'h0, 8'h0, 7'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b1;
      drive(7'h0, 8'h0, 7'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_single();
      test_priority();
      test_nesting();
      test_block_withdraw();
      test_reti_ack();
      test_idle_events();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Two-level priority interrupt arbiter for the 8051-class core.
- Collects the 7 peripheral interrupt flags (external INT0/INT1, timer TF0/TF1/TF2, serial RI|TI, spare), masks them with IE/IP from reg_ctrl, and selects one winner.
- Presents the winner's vector to the core sequencer through a rdy/ack handshake.
- Tracks nesting through per-level in-service bits and pulses hardware-clear strobes back to the flag owners.

Parameters:
- NUM_SRC, 7: number of interrupt sources. Fixed by IP width; the vector is 3 bits.
- HW_CLEAR_MASK, 7'b0001111: sources whose flag is cleared by hardware on ack (INT0, TF0, INT1, TF1).
- NONE_VECT, 3'b111: vector value driven when no request is presented.

Ports:
- interrupt_clk_i  in  1  block clock (core_clk domain)
- interrupt_reset_i  in  1  asynchronous reset, active-low
- interrupt_req_i  in  7  raw flags; bit0 INT0, 1 TF0, 2 INT1, 3 TF1, 4 RI|TI, 5 TF2, 6 spare
- interrupt_ie_i  in  8  IE register; bit7 = EA global enable, bits 6:0 per-source enable
- interrupt_ip_i  in  7  IP register; 1 = high priority
- interrupt_block_i  in  1  core busy (multi-cycle instruction, IE/IP write, RETI in flight); blocks new rdy
- interrupt_ack_i  in  1  single-cycle pulse: core has accepted the presented vector
- interrupt_reti_i  in  1  single-cycle pulse: RETI executed
- interrupt_rdy_o  out  1  vector valid and request presented
- interrupt_vect_o  out  3  winning source index, or NONE_VECT
- interrupt_clear_o  out  7  one-cycle hardware-clear strobes
- interrupt_in_service_o  out  2  bit1 high-level active, bit0 low-level active
- interrupt_na_o  out  1  1 when no interrupt is in service

Behaviour:
- Reset values: rdy 0, vect NONE_VECT, clear 0, in_service 2'b00, na 1, FSM IDLE. Reset is asynchronous and takes effect mid-handshake; the pending handshake is discarded.
- pending = req_i & ie_i[6:0] & {7{ie_i[7]}}.
- Eligibility:
  - in_service[1] set: nothing is eligible.
  - in_service[0] set: only high-priority pending sources are eligible.
  - Otherwise: all pending sources are eligible.
- Winner: eligible high-priority sources first, then eligible low-priority; lowest index wins within a level.
- FSM states: IDLE, PRESENT, HOLD.
  - IDLE: if a winner exists and block_i = 0, register the winner. Next cycle rdy = 1 with vect = winner → PRESENT. Latency is 1 cycle from a sampled request to rdy.
  - PRESENT: vect is frozen.
    - If ack_i: set in_service[level of winner], pulse clear_o[winner] for 1 cycle when HW_CLEAR_MASK[winner] = 1, drop rdy, vect → NONE_VECT, go to HOLD.
    - Else if the frozen source is no longer eligible (flag dropped, IE/IP change): withdraw; rdy = 0 next cycle → IDLE.
    - A newly arriving higher-priority source does not pre-empt a presented vector.
    - block_i does not cancel PRESENT.
  - HOLD: one dead cycle so the in-service update is visible → IDLE. rdy therefore stays low for at least 1 cycle after each ack.
- reti_i, processed in any state:
  - Clears in_service[1] if set, else in_service[0].
  - Ignored when in_service = 00.
- reti_i and ack_i in the same cycle: reti clears first, then ack sets. For example, low active plus high acked gives in_service 2'b10.
- ack_i outside PRESENT is ignored.
- na_o = ~|in_service, registered.
- clear_o is never asserted for more than 1 cycle per ack.

Test Plan:
- Single source: ie=8'h82, ip=0, pulse req[1] high. Required: rdy=1 with vect=1 on the cycle after sampling; ack → clear_o=7'b0000010 for 1 cycle, in_service=01, na=0; reti → in_service=00, na=1.
- Priority: req=7'b0010101, ie=8'hFF, ip=7'b0010000. Required: vect=4 (high priority wins). After ack, clear_o=0 (serial is not hardware-cleared), and with low pending and the high level active, rdy stays 0.
- Nesting: low source 0 in service, then req[3] rises with ip[3]=1. Required: rdy with vect=3; ack → in_service=11; first reti → 01; second reti → 00, after which the remaining low source is re-presented.
- Block and withdraw:
  - block_i=1 with req[0] pending: rdy stays 0 until block_i drops, then rdy rises 1 cycle later.
  - While PRESENT, clear ie[0]: rdy drops the next cycle and vect=7.
- Edge cases:
  - Same-cycle reti and ack (low active, high presented): in_service=10.
  - reti while idle: no change.
  - Assert reset while PRESENT: all outputs return to reset values immediately, independent of the clock.
